kuznechik_l_transform_iter: RTL



---
 rtl/kuznechik_l_transform_iter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/kuznechik_l_transform_iter.sv
// Iterative Kuznechik linear transform L = R^16 with a generic GF(2^8) multiplier and valid/ready handshake.
// Optional inverse transform (L^-1, selected by mode_i) is built when KUZNECHIK_L_INVERSE_EN is defined.
module kuznechik_l_transform_iter #(
    parameter int unsigned STEPS_PER_CYCLE = 1,
    parameter logic [7:0]  POLY            = 8'hC3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
`ifdef KUZNECHIK_L_INVERSE_EN
    input  logic         mode_i,
`endif
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         busy_o
);

    localparam int unsigned BLK_W    = 128;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned N_CYCLES = 16 / STEPS_PER_CYCLE;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CYCLES - 1);
    // Feedback coefficients, byte i multiplies a_i.
    localparam logic [BLK_W-1:0] L_COEF =
        128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

    generate
        if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
              STEPS_PER_CYCLE == 8 || STEPS_PER_CYCLE == 16)) begin : gen_bad_steps
            $error("STEPS_PER_CYCLE must be one of 1, 2, 4, 8, 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Shift-and-reduce multiply; constant b folds to a small XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? POLY : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] l_fn(input logic [BLK_W-1:0] s);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ gf_mul(s[8*i +: 8], L_COEF[8*i +: 8]);
        end
        return acc;
    endfunction

    function automatic logic [BLK_W-1:0] r_fwd(input logic [BLK_W-1:0] s);
        return {l_fn(s), s[127:8]};
    endfunction

`ifdef KUZNECHIK_L_INVERSE_EN
    function automatic logic [BLK_W-1:0] r_inv(input logic [BLK_W-1:0] s);
        return {s[119:0], l_fn({s[119:0], s[127:120]})};
    endfunction
`endif

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [BLK_W-1:0] stepped;
    logic             load;
`ifdef KUZNECHIK_L_INVERSE_EN
    logic             mode_q, mode_d;
`endif

    // Chain of STEPS_PER_CYCLE R (or R^-1) steps applied in one clock.
    always_comb begin : step_chain
        stepped = data_q;
        for (int unsigned k = 0; k < STEPS_PER_CYCLE; k++) begin
`ifdef KUZNECHIK_L_INVERSE_EN
            stepped = mode_q ? r_inv(stepped) : r_fwd(stepped);
`else
            stepped = r_fwd(stepped);
`endif
        end
    end

    // In DONE a new block may be accepted in the same cycle the result drains.
    assign in_ready_o = !rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready_i));

    always_comb begin : fsm_next
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        load   = 1'b0;
`ifdef KUZNECHIK_L_INVERSE_EN
        mode_d = mode_q;
`endif
        unique case (fsm_q)
            IDLE: begin
                if (in_valid_i) load = 1'b1;
            end
            RUN: begin
                data_d = stepped;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    fsm_d = DONE;
                    cnt_d = '0;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    fsm_d = IDLE;
                    if (in_valid_i) load = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (load) begin
            fsm_d  = RUN;
            cnt_d  = '0;
            data_d = in_data_i;
`ifdef KUZNECHIK_L_INVERSE_EN
            mode_d = mode_i;
`endif
        end
    end

    always_ff @(posedge clk) begin : fsm_regs
        if (rst) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            data_q <= '0;
`ifdef KUZNECHIK_L_INVERSE_EN
            mode_q <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
`ifdef KUZNECHIK_L_INVERSE_EN
            mode_q <= mode_d;
`endif
        end
    end

    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q == RUN);
    assign out_data_o  = data_q;

endmodule
